uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 152 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts a parallel word over valid/ready and
// frames it as start bit, DATA_WIDTH data bits, optional parity bit and
// one or two stop bits, each held for CLKS_PER_BIT clocks.
module uart_tx_serializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  ser_out,
  output logic                  busy,
  output logic                  done
);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
    $error("uart_tx_serializer: DATA_WIDTH must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
    $error("uart_tx_serializer: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  localparam int BW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW       = $clog2(DATA_WIDTH);
  localparam bit HAS_PAR  = (PARITY_MODE != 0);
  localparam bit ODD_PAR  = (PARITY_MODE == 2);
  localparam bit MSB_SEND = (MSB_FIRST != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [BW-1:0]         baud_cnt;
  logic [IW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  parity_q;
  logic                  ser_nx;
  logic                  done_nx;
  logic                  accept;
  logic                  baud_tc;
  logic                  last_data;
  logic                  last_stop;
  logic                  first_bit;
  logic                  next_bit;

  assign din_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = din_valid && din_ready;
  assign baud_tc   = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign last_data = (bit_cnt == IW'(DATA_WIDTH - 1));
  assign last_stop = (bit_cnt == IW'(STOP_BITS - 1));
  // ser_out is registered, so the bit about to go out is looked up one
  // shift ahead: first_bit before any shift, next_bit after the pending one.
  assign first_bit = MSB_SEND ? shreg[DATA_WIDTH-1] : shreg[0];
  assign next_bit  = MSB_SEND ? shreg[DATA_WIDTH-2] : shreg[1];

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ser_out <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      ser_out <= ser_nx;
      done    <= done_nx;
    end
  end

  // Next-state logic: advance only at baud terminal count
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = START;
      START:   if (baud_tc) state_nx = DATA;
      DATA:    if (baud_tc && last_data) state_nx = HAS_PAR ? PARITY : STOP;
      PARITY:  if (baud_tc) state_nx = STOP;
      STOP:    if (baud_tc && last_stop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: next serial level and end-of-frame pulse
  always_comb begin
    ser_nx  = ser_out;
    done_nx = 1'b0;
    case (state)
      IDLE:    ser_nx = accept ? 1'b0 : 1'b1;
      START:   if (baud_tc) ser_nx = first_bit;
      DATA: begin
        if (baud_tc) begin
          if (last_data) ser_nx = HAS_PAR ? parity_q : 1'b1;
          else           ser_nx = next_bit;
        end
      end
      PARITY:  if (baud_tc) ser_nx = 1'b1;
      STOP: begin
        ser_nx  = 1'b1;
        done_nx = baud_tc && last_stop;
      end
      default: ser_nx = 1'b1;
    endcase
  end

  // Datapath: baud counter, bit/stop counter, shift register, parity latch
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      parity_q <= 1'b0;
    end else if (state == IDLE) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      if (accept) begin
        shreg    <= din;
        parity_q <= (^din) ^ ODD_PAR;
      end
    end else begin
      baud_cnt <= baud_tc ? '0 : baud_cnt + BW'(1);
      if (baud_tc) begin
        case (state)
          DATA: begin
            bit_cnt <= last_data ? '0 : bit_cnt + IW'(1);
            shreg   <= MSB_SEND ? {shreg[DATA_WIDTH-2:0], 1'b0}
                                : {1'b0, shreg[DATA_WIDTH-1:1]};
          end
          STOP:    bit_cnt <= last_stop ? '0 : bit_cnt + IW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: five parameter sets driven from
// one directed sequence plus random words, checked cycle by cycle against an
// expected line waveform built from the frame format.
module tb_uart_tx_serializer;

  localparam int N = 5;
  localparam int PW [N] = '{8, 8, 8, 8, 5};
  localparam int PC [N] = '{4, 4, 4, 4, 2};
  localparam int PP [N] = '{0, 1, 2, 0, 0};
  localparam int PS [N] = '{1, 1, 1, 2, 1};
  localparam int PM [N] = '{0, 0, 0, 1, 0};

  logic       clk = 1'b0;
  logic       rst [N];
  logic [8:0] din [N];
  logic       vld [N];
  logic       rdy [N];
  logic       so  [N];
  logic       bsy [N];
  logic       dn  [N];

  int n_cmp = 0;
  int n_err = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1), .MSB_FIRST(0)) u0 (
    .clk(clk), .reset(rst[0]), .din(din[0][7:0]), .din_valid(vld[0]),
    .din_ready(rdy[0]), .ser_out(so[0]), .busy(bsy[0]), .done(dn[0]));
  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1), .MSB_FIRST(0)) u1 (
    .clk(clk), .reset(rst[1]), .din(din[1][7:0]), .din_valid(vld[1]),
    .din_ready(rdy[1]), .ser_out(so[1]), .busy(bsy[1]), .done(dn[1]));
  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1), .MSB_FIRST(0)) u2 (
    .clk(clk), .reset(rst[2]), .din(din[2][7:0]), .din_valid(vld[2]),
    .din_ready(rdy[2]), .ser_out(so[2]), .busy(bsy[2]), .done(dn[2]));
  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(2), .MSB_FIRST(1)) u3 (
    .clk(clk), .reset(rst[3]), .din(din[3][7:0]), .din_valid(vld[3]),
    .din_ready(rdy[3]), .ser_out(so[3]), .busy(bsy[3]), .done(dn[3]));
  uart_tx_serializer #(.DATA_WIDTH(5), .CLKS_PER_BIT(2), .PARITY_MODE(0), .STOP_BITS(1), .MSB_FIRST(0)) u4 (
    .clk(clk), .reset(rst[4]), .din(din[4][4:0]), .din_valid(vld[4]),
    .din_ready(rdy[4]), .ser_out(so[4]), .busy(bsy[4]), .done(dn[4]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected line level for every cycle of one frame, starting at the first
  // start-bit cycle: list the frame's bits, then repeat each CLKS_PER_BIT times.
  task automatic build(input int i, input logic [8:0] w);
    bit bits[$];
    int ones;
    int idx;
    ones = 0;
    bits.push_back(1'b0);
    for (int k = 0; k < PW[i]; k++) begin
      idx = (PM[i] != 0) ? (PW[i] - 1 - k) : k;
      bits.push_back(w[idx]);
      ones += int'(w[k]);
    end
    if (PP[i] == 1) bits.push_back(((ones % 2) == 1));
    if (PP[i] == 2) bits.push_back(((ones % 2) == 0));
    for (int s = 0; s < PS[i]; s++) bits.push_back(1'b1);
    exp_q.delete();
    foreach (bits[b])
      for (int c = 0; c < PC[i]; c++) exp_q.push_back(bits[b]);
  endtask

  // Offer a word at a negedge while the block is idle; returns at the
  // negedge of the first start-bit cycle.
  task automatic start(input int i, input logic [8:0] w);
    din[i] = w;
    vld[i] = 1'b1;
    chk($sformatf("u%0d ready_before_accept", i), 32'(rdy[i]), 32'd1);
    build(i, w);
    @(negedge clk);
  endtask

  // Check every frame cycle; stop_at >= 0 returns early at that cycle.
  // chain leaves din_valid high with nxt so the next frame starts right
  // after the done cycle.
  task automatic body(input int i, input int stop_at, input bit disturb,
                      input bit chain, input logic [8:0] nxt);
    int len;
    len = exp_q.size();
    for (int n = 0; n < len; n++) begin
      chk($sformatf("u%0d ser_out c%0d", i, n), 32'(so[i]), 32'(exp_q[n]));
      chk($sformatf("u%0d busy c%0d", i, n), 32'(bsy[i]), 32'd1);
      chk($sformatf("u%0d ready c%0d", i, n), 32'(rdy[i]), 32'd0);
      chk($sformatf("u%0d done c%0d", i, n), 32'(dn[i]), 32'd0);
      if (n == stop_at) return;
      if (n == len - 1) begin
        vld[i] = chain;
        din[i] = nxt;
      end else if (disturb) begin
        din[i] = 9'($urandom);
        vld[i] = 1'($urandom);
      end
      @(negedge clk);
    end
    chk($sformatf("u%0d done_pulse", i), 32'(dn[i]), 32'd1);
    chk($sformatf("u%0d ser_out_done", i), 32'(so[i]), 32'd1);
    chk($sformatf("u%0d ready_done", i), 32'(rdy[i]), 32'd1);
    chk($sformatf("u%0d busy_done", i), 32'(bsy[i]), 32'd0);
    @(negedge clk);
    if (!chain) begin
      chk($sformatf("u%0d done_single", i), 32'(dn[i]), 32'd0);
      chk($sformatf("u%0d ser_out_idle", i), 32'(so[i]), 32'd1);
    end
  endtask

  initial begin
    logic [8:0] w;
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1;
      vld[i] = 1'b0;
      din[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d rst ser_out", i), 32'(so[i]), 32'd1);
      chk($sformatf("u%0d rst ready", i), 32'(rdy[i]), 32'd1);
      chk($sformatf("u%0d rst busy", i), 32'(bsy[i]), 32'd0);
      chk($sformatf("u%0d rst done", i), 32'(dn[i]), 32'd0);
      rst[i] = 1'b0;
    end
    @(negedge clk);

    // Basic 8N1 frame
    start(0, 9'h0A5);
    body(0, -1, 1'b0, 1'b0, '0);

    // Even and odd parity
    start(1, 9'h0A5); body(1, -1, 1'b0, 1'b0, '0);
    start(2, 9'h0A5); body(2, -1, 1'b0, 1'b0, '0);
    start(1, 9'h007); body(1, -1, 1'b0, 1'b0, '0);
    start(2, 9'h007); body(2, -1, 1'b0, 1'b0, '0);

    // MSB first, two stop bits
    start(3, 9'h001);
    body(3, -1, 1'b0, 1'b0, '0);

    // Back-to-back with din_valid held, then a disturbed second frame
    start(0, 9'h011);
    body(0, -1, 1'b0, 1'b1, 9'h022);
    build(0, 9'h022);
    body(0, -1, 1'b1, 1'b0, '0);

    // Disturbed inputs during a whole frame
    start(0, 9'h05A);
    body(0, -1, 1'b1, 1'b0, '0);

    // Reset in the middle of data bit 3
    start(0, 9'($urandom_range(0, 255)));
    body(0, 4 * PC[0] + PC[0] / 2, 1'b0, 1'b0, '0);
    vld[0] = 1'b0;
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("u0 abort ser_out", 32'(so[0]), 32'd1);
    chk("u0 abort busy", 32'(bsy[0]), 32'd0);
    chk("u0 abort ready", 32'(rdy[0]), 32'd1);
    chk("u0 abort done", 32'(dn[0]), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("u0 post_abort done k%0d", k), 32'(dn[0]), 32'd0);
      chk($sformatf("u0 post_abort ser_out k%0d", k), 32'(so[0]), 32'd1);
    end
    start(0, 9'h03C);
    body(0, -1, 1'b0, 1'b0, '0);

    // Five data bits at two clocks per bit
    start(4, 9'h016);
    body(4, -1, 1'b0, 1'b0, '0);

    // Random words on every configuration
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        w = 9'($urandom);
        start(i, w);
        body(i, -1, 1'($urandom), 1'b0, '0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
